dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the MEM-stage load/store slot of the 2-issue VLIW pipeline; the MEM stage is the initiator.
- Accepts one byte-wide load/store request at a time and services it after a programmable number of wait cycles.
- Returns the read byte zero-extended to 32 bits.
- Drives a stall back to the pipeline while an access is outstanding, and flags out-of-range addresses.

Parameters:
- ADDR_BITS, 8, byte-address width of the backing array (depth 2^ADDR_BITS bytes).
- LATENCY, 2, wait cycles between acceptance and response (legal 0..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  MEM stage presents an access.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address (p3_mem_address).
- req_wdata  input  8  store data (p3_mem_reg_rd).
- req_ready  output  1  responder can accept this cycle.
- resp_valid  output  1  one-cycle completion pulse, for loads and stores.
- resp_rdata  output  32  load data {24'b0, byte}; 0 for stores and faults.
- mem_stall  output  1  pipeline must hold the MEM stage and everything upstream.
- addr_fault  output  1  sticky out-of-range indication.
- fault_clear  input  1  clears addr_fault.

Behaviour:
- Reset: synchronous, active-high, one clock on clk.
  - Outputs: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_stall=0, addr_fault=0, wait counter=0.
  - The backing array is not cleared.
- States: IDLE, BUSY, RESP.
- req_ready = (state==IDLE). Acceptance is req_valid && req_ready.
- Accept (cycle T): latch write, addr, wdata; load counter with LATENCY.
  - LATENCY==0: go to RESP.
  - Otherwise: go to BUSY.
- BUSY: decrement counter each cycle. When the counter is 1, the next state is RESP and the access executes at that edge:
  - Store writes array[addr].
  - Load captures array[addr] into resp_rdata.
  - For LATENCY==0 the access executes at the accept edge.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - req_ready=0 in RESP, so a req_valid still held by the departing instruction is not re-accepted.
- Latency: accept at T, resp_valid at T+LATENCY+1. Minimum back-to-back spacing is LATENCY+2 cycles.
- mem_stall = (req_valid && req_ready) || (state==BUSY). Combinational from req_valid.
  - High from the accept cycle through the last BUSY cycle; low in the RESP cycle so the pipeline advances with resp_rdata.
- resp_rdata holds its value after RESP until the next access executes.
- Out-of-range: req_addr[31:ADDR_BITS] != 0.
  - No array access (store dropped, load returns 0).
  - Handshake and timing are unchanged.
  - addr_fault sets at the execute edge.
- addr_fault is sticky; fault_clear clears it. A new fault in the same cycle as fault_clear wins (stays 1).
- Load and store to the same address in consecutive accesses: the load sees the stored value (no write buffering).
- Reset mid-operation (BUSY or RESP): return to IDLE immediately.
  - A pending store that has not yet executed is discarded.
  - resp_valid is not asserted for it.
- req_wdata, req_addr and req_write changes after acceptance are ignored.

Test Plan:
- LATENCY=2: store 0xA5 to 0x10, accept at T0 → mem_stall high T0..T2, resp_valid only at T3, req_ready low T1..T3, high T4; array[0x10]=0xA5.
- Load from 0x10 after the above → resp_valid at accept+3, resp_rdata=0x000000A5; a held req_valid during RESP is not re-accepted (no second resp_valid).
- LATENCY=0: load accepted at T0 → mem_stall high T0 only, resp_valid at T1; back-to-back loads from 0x00 and 0x01 complete at T1 and T3.
- Store to 0x00000100 with ADDR_BITS=8 → resp_valid normally, array unchanged, addr_fault=1 and stays 1. Assert fault_clear alone → 0. Assert fault_clear together with another fault → stays 1.
- Reset asserted in the first BUSY cycle of a store 0x3C to 0x20 → next cycle IDLE, req_ready=1, mem_stall=0, no resp_valid; a later load of 0x20 returns the prior contents, not 0x3C.
- Random req_valid toggling with checker → exactly one resp_valid per accept, never an accept while state!=IDLE, and resp_rdata[31:8] is always 0.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
// Byte-wide data-memory responder for the MEM-stage load/store slot.
// One access at a time: it is accepted when idle, executes after LATENCY
// wait cycles, and completes with a one-cycle resp_valid pulse.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   req_valid        MEM stage presents an access
//   req_write        1 = store, 0 = load
//   req_addr         32-bit byte address
//   req_wdata        store byte
//   req_ready        responder idle, can accept this cycle
//   resp_valid       one-cycle completion pulse (loads and stores)
//   resp_rdata       {24'b0, byte} for in-range loads, 0 otherwise; held
//   mem_stall        hold the MEM stage and everything upstream
//   addr_fault       sticky out-of-range flag
//   fault_clear      clears addr_fault (a same-cycle new fault wins)
module dmem_responder #(
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        mem_stall,
   output logic        addr_fault,
   input  logic        fault_clear
);
   localparam int         DEPTH = 1 << ADDR_BITS;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic                   write_q, write_d;
   logic                   oob_q, oob_d;
   logic [ADDR_BITS-1:0]   addr_q, addr_d;
   logic [7:0]             wdata_q, wdata_d;
   logic                   req_ready_q, req_ready_d;
   logic                   resp_valid_q, resp_valid_d;
   logic [31:0]            resp_rdata_q, resp_rdata_d;
   logic                   addr_fault_q, addr_fault_d;

   logic [7:0]             mem_q [DEPTH];

   logic                   accept_s;
   logic                   exec_s;
   logic                   ex_write_s;
   logic                   ex_oob_s;
   logic [ADDR_BITS-1:0]   ex_addr_s;
   logic [7:0]             ex_wdata_s;
   logic                   mem_we_s;

   // req_ready_q is high exactly when the FSM is IDLE.
   assign accept_s   = req_valid && req_ready_q;
   assign mem_stall  = accept_s || (state_q == BUSY);

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign addr_fault = addr_fault_q;

   // Next-state, access execution and output computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      oob_d      = oob_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      exec_s     = 1'b0;
      ex_write_s = write_q;
      ex_oob_s   = oob_q;
      ex_addr_s  = addr_q;
      ex_wdata_s = wdata_q;

      case (state_q)
         IDLE: begin
            if (accept_s) begin
               write_d = req_write;
               oob_d   = |req_addr[31:ADDR_BITS];
               addr_d  = req_addr[ADDR_BITS-1:0];
               wdata_d = req_wdata;
               cnt_d   = LAT;
               if (LAT == 4'd0) begin
                  // Zero wait: execute straight from the request inputs.
                  state_d    = RESP;
                  exec_s     = 1'b1;
                  ex_write_s = req_write;
                  ex_oob_s   = |req_addr[31:ADDR_BITS];
                  ex_addr_s  = req_addr[ADDR_BITS-1:0];
                  ex_wdata_s = req_wdata;
               end else begin
                  state_d = BUSY;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
               exec_s  = 1'b1;
            end else begin
               state_d = BUSY;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      resp_rdata_d = resp_rdata_q;
      addr_fault_d = addr_fault_q && !fault_clear;
      mem_we_s     = 1'b0;
      if (exec_s) begin
         if (ex_oob_s) begin
            // Set after the clear term so a new fault beats fault_clear.
            addr_fault_d = 1'b1;
            resp_rdata_d = 32'd0;
         end else if (ex_write_s) begin
            mem_we_s     = !reset;
            resp_rdata_d = 32'd0;
         end else begin
            resp_rdata_d = {24'd0, mem_q[ex_addr_s]};
         end
      end else begin
         resp_rdata_d = resp_rdata_q;
      end

      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
   end

   // Control and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         write_q      <= 1'b0;
         oob_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= 8'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         addr_fault_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         write_q      <= write_d;
         oob_q        <= oob_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         addr_fault_q <= addr_fault_d;
      end
   end

   // Backing array; deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[ex_addr_s] <= ex_wdata_s;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: a LATENCY=2 instance (dut) and a
// LATENCY=0 instance (dut0), both with ADDR_BITS=8.
module tb_dmem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid, req_write, fault_clear;
   logic [31:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_ready, resp_valid, mem_stall, addr_fault;
   logic [31:0] resp_rdata;

   logic        z_valid, z_write;
   logic [31:0] z_addr;
   logic [7:0]  z_wdata;
   logic        z_ready, z_rv, z_stall, z_fault;
   logic [31:0] z_rdata;

   int errors = 0;
   int checks = 0;

   dmem_responder #(.ADDR_BITS(8), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mem_stall(mem_stall),
      .addr_fault(addr_fault), .fault_clear(fault_clear));

   dmem_responder #(.ADDR_BITS(8), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .req_valid(z_valid), .req_write(z_write),
      .req_addr(z_addr), .req_wdata(z_wdata), .req_ready(z_ready),
      .resp_valid(z_rv), .resp_rdata(z_rdata), .mem_stall(z_stall),
      .addr_fault(z_fault), .fault_clear(1'b0));

   // LATENCY=0 stimulus/expectation table, one entry per cycle.
   bit          tv [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
   bit          tw [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [31:0] ta [8] = '{32'h0, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h1};
   logic [7:0]  td [8] = '{8'h11, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   bit          erv[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   bit          est[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic [31:0] erd[8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h11, 32'h22};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one access on dut; report completion cycle (-1 if none) and data.
   task automatic acc(input logic w, input logic [31:0] a, input logic [7:0] d,
                      output logic [31:0] rd, output int lat);
      lat = -1;
      rd  = 32'h0;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (n != 0 && resp_valid === 1'b1 && lat < 0) begin
            lat = n;
            rd  = resp_rdata;
         end
         tick();
         req_valid = 1'b0;
         if (lat >= 0) break;
      end
   endtask

   task automatic test_reset();
      req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 8'h0;
      fault_clear = 1'b0;
      z_valid = 1'b0; z_write = 1'b0; z_addr = 32'h0; z_wdata = 8'h0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b want 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", resp_rdata); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", mem_stall); end
      checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", addr_fault); end
      checks++; if (z_ready !== 1'b1) begin errors++; $display("FAIL reset_z_ready got %b want 1", z_ready); end
      tick();
   endtask

   task automatic test_store_lat2();
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 8'hA5;
      for (int k = 0; k <= 4; k++) begin
         #1;
         checks++; if (mem_stall !== (k <= 2)) begin errors++; $display("FAIL store_stall T%0d got %b want %b", k, mem_stall, (k <= 2)); end
         checks++; if (resp_valid !== (k == 3)) begin errors++; $display("FAIL store_rv T%0d got %b want %b", k, resp_valid, (k == 3)); end
         checks++; if (req_ready !== (k == 0 || k == 4)) begin errors++; $display("FAIL store_ready T%0d got %b want %b", k, req_ready, (k == 0 || k == 4)); end
         tick();
         // Changes after acceptance must be ignored.
         req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h55; req_wdata = 8'hFF;
      end
   endtask

   task automatic test_load_held();
      int rv_count = 0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
      for (int k = 0; k <= 6; k++) begin
         #1;
         if (resp_valid === 1'b1) rv_count++;
         if (k == 3) begin
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL load_rv got %b want 1", resp_valid); end
            checks++; if (resp_rdata !== 32'h000000A5) begin errors++; $display("FAIL load_rdata got %h want 000000a5", resp_rdata); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL load_ready_resp got %b want 0", req_ready); end
         end
         if (k == 5) begin
            checks++; if (resp_rdata !== 32'h000000A5) begin errors++; $display("FAIL load_hold got %h want 000000a5", resp_rdata); end
         end
         tick();
         if (k >= 3) req_valid = 1'b0;
      end
      checks++; if (rv_count != 1) begin errors++; $display("FAIL load_single_resp got %0d want 1", rv_count); end
   endtask

   task automatic test_lat0();
      for (int c = 0; c < 8; c++) begin
         z_valid = tv[c]; z_write = tw[c]; z_addr = ta[c]; z_wdata = td[c];
         #1;
         checks++; if (z_rv !== erv[c]) begin errors++; $display("FAIL lat0_rv c%0d got %b want %b", c, z_rv, erv[c]); end
         checks++; if (z_stall !== est[c]) begin errors++; $display("FAIL lat0_stall c%0d got %b want %b", c, z_stall, est[c]); end
         checks++; if (z_rdata !== erd[c]) begin errors++; $display("FAIL lat0_rdata c%0d got %h want %h", c, z_rdata, erd[c]); end
         tick();
      end
      z_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      int lat;
      int rv_count = 0;
      acc(1'b1, 32'h20, 8'h5A, rd, lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL rmid_pre_lat got %0d want 3", lat); end
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 8'h3C;
      tick();
      req_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b want 1", req_ready); end
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", mem_stall); end
      for (int k = 0; k < 4; k++) begin
         if (resp_valid === 1'b1) rv_count++;
         tick();
         #1;
      end
      checks++; if (rv_count != 0) begin errors++; $display("FAIL rmid_no_resp got %0d want 0", rv_count); end
      tick();
      acc(1'b0, 32'h20, 8'h00, rd, lat);
      checks++; if (rd !== 32'h5A) begin errors++; $display("FAIL rmid_data got %h want 0000005a", rd); end
   endtask

   task automatic test_fault();
      logic [31:0] rd;
      int lat;
      #1;
      checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL fault_init got %b want 0", addr_fault); end
      tick();
      acc(1'b1, 32'h00, 8'h77, rd, lat);
      acc(1'b1, 32'h100, 8'h99, rd, lat);
      checks++; if (lat != 3) begin errors++; $display("FAIL fault_lat got %0d want 3", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL fault_store_rdata got %h want 0", rd); end
      checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL fault_set got %b want 1", addr_fault); end
      tick(); tick();
      checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b want 1", addr_fault); end
      acc(1'b0, 32'h00, 8'h00, rd, lat);
      checks++; if (rd !== 32'h77) begin errors++; $display("FAIL fault_array_kept got %h want 00000077", rd); end
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      #1;
      checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", addr_fault); end
      tick();
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h200;
      tick();
      req_valid = 1'b0;
      tick();
      fault_clear = 1'b1;
      tick();
      fault_clear = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL fault_load_rv got %b want 1", resp_valid); end
      checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL fault_vs_clear got %b want 1", addr_fault); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL fault_load_rdata got %h want 0", resp_rdata); end
      tick();
   endtask

   task automatic test_random();
      logic [7:0]  shadow [16];
      bit          known  [16];
      int          ph = 0;
      int          accepts = 0;
      int          resps = 0;
      logic [31:0] exp_rd = 32'h0;
      bit          chk_data = 1'b0;
      bit          pend_oob = 1'b0;
      logic [3:0]  idx;
      for (int i = 0; i < 16; i++) known[i] = 1'b0;
      for (int c = 0; c < 300; c++) begin
         req_valid = (c < 290) ? 1'($urandom_range(0, 1)) : 1'b0;
         req_write = 1'($urandom_range(0, 1));
         req_wdata = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) req_addr = 32'h100 | 32'($urandom_range(0, 15));
         else req_addr = 32'($urandom_range(0, 15));
         #1;
         checks++; if (req_ready !== (ph == 0)) begin errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, req_ready, (ph == 0)); end
         checks++; if (mem_stall !== ((req_valid && ph == 0) || ph == 1 || ph == 2)) begin errors++; $display("FAIL rnd_stall c%0d got %b", c, mem_stall); end
         checks++; if (resp_valid !== (ph == 3)) begin errors++; $display("FAIL rnd_rv c%0d got %b want %b", c, resp_valid, (ph == 3)); end
         checks++; if (resp_rdata[31:8] !== 24'h0) begin errors++; $display("FAIL rnd_upper c%0d got %h want 0", c, resp_rdata[31:8]); end
         if (resp_valid === 1'b1) resps++;
         if (ph == 3) begin
            if (chk_data) begin
               checks++; if (resp_rdata !== exp_rd) begin errors++; $display("FAIL rnd_rdata c%0d got %h want %h", c, resp_rdata, exp_rd); end
            end
            if (pend_oob) begin
               checks++; if (addr_fault !== 1'b1) begin errors++; $display("FAIL rnd_fault c%0d got %b want 1", c, addr_fault); end
            end
         end
         if (ph == 0 && req_valid) begin
            accepts++;
            ph = 1;
            idx = req_addr[3:0];
            pend_oob = |req_addr[31:8];
            if (pend_oob) begin
               exp_rd = 32'h0; chk_data = 1'b1;
            end else if (req_write) begin
               shadow[idx] = req_wdata; known[idx] = 1'b1;
               exp_rd = 32'h0; chk_data = 1'b1;
            end else begin
               exp_rd = {24'h0, shadow[idx]}; chk_data = known[idx];
            end
         end else if (ph == 3) begin
            ph = 0;
         end else if (ph > 0) begin
            ph++;
         end
         tick();
      end
      checks++; if (resps != accepts) begin errors++; $display("FAIL rnd_count got %0d responses want %0d", resps, accepts); end
   endtask

   initial begin
      test_reset();
      test_store_lat2();
      test_load_held();
      test_lat0();
      test_reset_mid();
      test_fault();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
